// File: rtl/bcd_serial_addsub_if.sv
// bcd_serial_addsub_if: start/done request bus carrying BCD operands, result and status flags.
interface bcd_serial_addsub_if #(parameter int DIGITS = 4);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  carry_out;
  logic                  negative;
  logic                  invalid;
  modport master (output start, sub, a, b, input busy, done, result, carry_out, negative, invalid);
  modport slave  (input start, sub, a, b, output busy, done, result, carry_out, negative, invalid);
endinterface

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial packed-BCD add/subtract, LSD first, sign-magnitude subtraction result.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                nrst,
  bcd_serial_addsub_if.slave  bus
);
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);
  typedef enum logic [1:0] {IDLE, ADD, NEG, DONE} state_t;
  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             sub_q, sub_d, cy_q, cy_d, co_q, co_d, neg_q, neg_d, inv_q, inv_d;
  logic [3:0]       x, y, bdig, dig;
  logic [4:0]       s;
  logic             c, last;
  function automatic logic bad_digit(input logic [W-1:0] v);
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad_digit |= v[4*i +: 4] > 4'd9;
  endfunction
  // One shared digit adder: ADD sums a with b (or 9-b), NEG adds carry to 9-result.
  always_comb begin
    bdig = b_q[4*idx_q +: 4];
    x = state_q == NEG ? 4'd9 - res_q[4*idx_q +: 4] : a_q[4*idx_q +: 4];
    y = state_q == NEG ? 4'd0 : (sub_q ? 4'd9 - bdig : bdig);
    s = {1'b0, x} + {1'b0, y} + {4'b0, cy_q};
    c = s > 5'd9;
    dig = c ? s[3:0] + 4'd6 : s[3:0];
    last = idx_q == LAST;
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sub_d = sub_q;
    idx_d = idx_q;
    cy_d = cy_q;
    res_d = res_q;
    co_d = co_q;
    neg_d = neg_q;
    inv_d = inv_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d = bus.a;
          b_d = bus.b;
          sub_d = bus.sub;
          idx_d = '0;
          cy_d = bus.sub;
          inv_d = bad_digit(bus.a) | bad_digit(bus.b);
          res_d = '0;
          co_d = 1'b0;
          neg_d = 1'b0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        res_d[4*idx_q +: 4] = dig;
        cy_d = c;
        idx_d = last ? '0 : idx_q + 1'b1;
        if (last) begin
          co_d = !sub_q && c;
          neg_d = sub_q && !c;
          cy_d = sub_q && !c ? 1'b1 : c;
          state_d = sub_q && !c ? NEG : DONE;
        end
      end
      NEG: begin
        res_d[4*idx_q +: 4] = dig;
        cy_d = c;
        idx_d = last ? '0 : idx_q + 1'b1;
        state_d = last ? DONE : NEG;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      idx_q <= '0;
      cy_q <= 1'b0;
      res_q <= '0;
      co_q <= 1'b0;
      neg_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sub_q <= sub_d;
      idx_q <= idx_d;
      cy_q <= cy_d;
      res_q <= res_d;
      co_q <= co_d;
      neg_q <= neg_d;
      inv_q <= inv_d;
    end
  end
  assign bus.busy = state_q == ADD || state_q == NEG;
  assign bus.done = state_q == DONE;
  assign bus.result = res_q;
  assign bus.carry_out = co_q;
  assign bus.negative = neg_q;
  assign bus.invalid = inv_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb_bcd_serial_addsub: directed and random checks of 4-digit and 1-digit builds against an integer model.
module tb_bcd_serial_addsub;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  bcd_serial_addsub_if #(.DIGITS(4)) bus4 ();
  bcd_serial_addsub_if #(.DIGITS(1)) bus1 ();
  bcd_serial_addsub #(.DIGITS(4)) dut4 (.clk(clk), .nrst(nrst), .bus(bus4));
  bcd_serial_addsub #(.DIGITS(1)) dut1 (.clk(clk), .nrst(nrst), .bus(bus1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic int bcd2i(input logic [15:0] v, input int d);
    int r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction
  function automatic logic [15:0] i2bcd(input int x, input int d);
    logic [15:0] r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s, input int d,
                                output logic [15:0] r, output logic co, output logic neg, output logic inv,
                                output int lat);
    int pw = 10 ** d;
    int va = bcd2i(a, d);
    int vb = bcd2i(b, d);
    inv = 1'b0;
    for (int i = 0; i < d; i++) inv |= (a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9);
    if (!s) begin
      r = i2bcd((va + vb) % pw, d);
      co = (va + vb) >= pw;
      neg = 1'b0;
      lat = d;
    end else begin
      neg = va < vb;
      r = i2bcd(neg ? vb - va : va - vb, d);
      co = 1'b0;
      lat = neg ? 2 * d : d;
    end
  endfunction
  function automatic logic [15:0] rnd_bcd(input int d);
    logic [15:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction
  // Drives start immediately and returns #1 after the edge where done rises (the DONE cycle).
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic s, input string tag);
    logic [15:0] er;
    logic eco, eneg, einv;
    int lat, n;
    model(a, b, s, 4, er, eco, eneg, einv, lat);
    bus4.a = a;
    bus4.b = b;
    bus4.sub = s;
    bus4.start = 1'b1;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    n = 0;
    while (!bus4.done && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, " latency"}, n, lat);
    if (!einv) chk({tag, " result"}, {16'b0, bus4.result}, {16'b0, er});
    chk({tag, " carry"}, {31'b0, bus4.carry_out}, {31'b0, eco});
    if (!einv) chk({tag, " neg"}, {31'b0, bus4.negative}, {31'b0, eneg});
    chk({tag, " invalid"}, {31'b0, bus4.invalid}, {31'b0, einv});
  endtask
  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic s, input string tag);
    logic [15:0] er;
    logic eco, eneg, einv;
    int lat, n;
    model({12'b0, a}, {12'b0, b}, s, 1, er, eco, eneg, einv, lat);
    bus1.a = a;
    bus1.b = b;
    bus1.sub = s;
    bus1.start = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    n = 0;
    while (!bus1.done && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " result"}, {28'b0, bus1.result}, {16'b0, er});
    chk({tag, " carry"}, {31'b0, bus1.carry_out}, {31'b0, eco});
    chk({tag, " neg"}, {31'b0, bus1.negative}, {31'b0, eneg});
  endtask
  initial begin
    int n;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset flags", {26'b0, bus4.busy, bus4.done, bus4.carry_out, bus4.negative, bus4.invalid, bus1.busy}, 32'h0);
    chk("reset result", {16'b0, bus4.result}, 32'h0);
    nrst = 1'b1;
    run4(16'h1234, 16'h5678, 1'b0, "add1234");
    @(posedge clk);
    #1;
    chk("done pulse width", {30'b0, bus4.done, bus4.busy}, 32'h0);
    chk("result held", {16'b0, bus4.result}, 32'h6912);
    run4(16'h9999, 16'h0001, 1'b0, "add9999");
    run4(16'h5000, 16'h1234, 1'b1, "sub5000");
    run4(16'h0123, 16'h0456, 1'b1, "sub0123");
    run4(16'h0042, 16'h0042, 1'b1, "subeq");
    run4(16'h00A0, 16'h0001, 1'b0, "invalid");
    @(posedge clk);
    #1;
    bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.sub = 1'b0; bus4.start = 1'b1;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    @(posedge clk);
    #1 bus4.a = 16'h9999; bus4.b = 16'h9999; bus4.sub = 1'b1; bus4.start = 1'b1;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    n = 2;
    while (!bus4.done && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("midstart latency", n, 4);
    chk("midstart result", {16'b0, bus4.result}, 32'h3333);
    chk("midstart neg", {31'b0, bus4.negative}, 32'h0);
    run4(16'h0007, 16'h0008, 1'b1, "backtoback");
    bus4.a = 16'h0123; bus4.b = 16'h0456; bus4.sub = 1'b1; bus4.start = 1'b1;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("in NEG busy", {31'b0, bus4.busy}, 32'h1);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset flags", {27'b0, bus4.busy, bus4.done, bus4.carry_out, bus4.negative, bus4.invalid}, 32'h0);
    chk("midreset result", {16'b0, bus4.result}, 32'h0);
    nrst = 1'b1;
    run4(16'h4321, 16'h1234, 1'b1, "afterreset");
    for (int i = 0; i < 25; i++) run4(rnd_bcd(4), rnd_bcd(4), 1'($urandom_range(0, 1)), $sformatf("rnd4_%0d", i));
    run1(4'h9, 4'h9, 1'b0, "d1add");
    run1(4'h3, 4'h7, 1'b1, "d1sub");
    for (int i = 0; i < 10; i++) run1(4'(rnd_bcd(1)), 4'(rnd_bcd(1)), 1'($urandom_range(0, 1)), $sformatf("rnd1_%0d", i));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
Multi-digit packed-BCD adder/subtractor that processes one decimal digit per clock, least significant digit first. It is the parametrised, sequential successor to the fixed 2-digit combinational BCD add/sub datapath. Subtraction returns sign plus magnitude rather than a raw nines'-complement word. It sits between operand registers and the display/accumulator path, with a start/done handshake.

Parameters:
DIGITS, 4, number of BCD digits per operand and result (≥1); operand width = 4*DIGITS bits
CNT_W, $clog2(DIGITS+1), width of the internal digit counter (derived, not overridden)

Ports:
clk  in  1  clock, rising-edge
nrst  in  1  synchronous active-low reset
start  in  1  request; sampled only when busy=0
sub  in  1  0 = a+b, 1 = a-b; latched with start
a  in  4*DIGITS  packed BCD operand, digit 0 in bits [3:0]
b  in  4*DIGITS  packed BCD operand
busy  out  1  high while an operation is in progress (ADD or NEG state)
done  out  1  one-cycle pulse: result and flags valid
result  out  4*DIGITS  packed BCD result (add: sum mod 10^DIGITS; sub: |a-b|)
carry_out  out  1  add: decimal overflow beyond DIGITS digits; sub: always 0
negative  out  1  sub only: 1 when a<b
invalid  out  1  1 when any digit of the latched a or b was >9

Behaviour:
- Single clock, synchronous active-low reset nrst; all state updates on rising clk.
- Reset (nrst=0 at an edge, including mid-operation) -> state IDLE, busy=0, done=0, result=0, carry_out=0, negative=0, invalid=0. Any operation in flight is abandoned.
- States: IDLE, ADD, NEG, DONE. busy=1 in ADD/NEG only. done=1 in DONE only.
- IDLE/DONE + start=1 at edge k:
  - latch a, b, sub into operand registers;
  - digit index i=0;
  - carry register = sub (the +1 of the ten's complement);
  - invalid = OR over all digits of (digit>9) for a and b;
  - clear result, carry_out, negative;
  - go to ADD.
  - start is therefore accepted in the DONE cycle, so back-to-back operations are allowed.
- IDLE/DONE + start=0: DONE -> IDLE. Outputs hold their last values until the next accepted start.
- start while busy=1: ignored. Operands and sub are not re-latched.
- ADD, one digit per edge:
  - bd = sub ? 9-b[i] : b[i];
  - s = a[i]+bd+carry (5 bits);
  - if s>9 or s≥16: result[i] = (s+6) mod 16, carry=1; else result[i] = s, carry=0;
  - i++.
- After the last digit (i=DIGITS-1):
  - add -> carry_out = final carry, go to DONE;
  - sub with final carry=1 -> a≥b, negative=0, go to DONE;
  - sub with final carry=0 -> a<b, negative=1, i=0, carry=1, go to NEG.
- NEG, one digit per edge: result[i] = decimal digit of (9-result[i]+carry) with BCD carry; i++. After digit DIGITS-1, go to DONE. This converts the ten's complement to a magnitude.
- Latency from the accepting edge k:
  - done is high in the cycle following edge k+DIGITS (add, or sub with a≥b);
  - done is high in the cycle following edge k+2*DIGITS (sub with a<b).
- Equal operands on sub -> result 0, negative=0. Zero is never reported negative.
- Invalid digits: computation still runs and the result is unspecified, but invalid=1 is guaranteed with done.
- DIGITS=1 is legal; the counter must not overflow for any DIGITS.

Test Plan:
- DIGITS=4, add 0x1234+0x5678 -> result 0x6912, carry_out=0, negative=0; done exactly 1 cycle, 4 edges after the start edge.
- DIGITS=4, add 0x9999+0x0001 -> result 0x0000, carry_out=1. Sub 0x5000-0x1234 -> 0x3766, negative=0, 4-edge latency.
- DIGITS=4, sub 0x0123-0x0456 -> result 0x0333, negative=1, 8-edge latency. Sub 0x0042-0x0042 -> 0x0000, negative=0.
- Start pulsed again mid-ADD with different operands -> ignored, first result correct. Start in the DONE cycle -> second op begins, correct result.
- nrst=0 during NEG -> next cycle all outputs 0, busy=0. New start afterwards runs normally.
- a=0x00A0 -> invalid=1 at done. DIGITS=1 build: 9+9 -> result 0x8, carry_out=1; 3-7 -> 0x4, negative=1, done after 2 edges.
